// File: rtl/enigma_pkg.sv
// Shared letter constants, FSM state encoding and the debug view used by
// the Enigma rotor-stepping blocks.
package enigma_pkg;

    localparam int LETTER_W         = 5;
    localparam int NUM_LETTERS      = 26;
    localparam int NOTCH1_DEFAULT   = 16;
    localparam int SETTLE_W         = 4;

    localparam logic [LETTER_W-1:0] INVALID_LETTER = 5'd31;
    localparam logic [LETTER_W-1:0] LAST_LETTER    = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic [1:0]          state;
        logic [SETTLE_W-1:0] settle_cnt;
        logic                r1_notch;
        logic                r2_notch;
        logic                pend_full;
    } dbg_t;

    // Inputs are 5 bits wide, so one conditional subtract covers 26..31.
    function automatic logic [LETTER_W-1:0] letter_mod26(input logic [LETTER_W-1:0] v);
        return (v > LAST_LETTER) ? v - LETTER_W'(NUM_LETTERS) : v;
    endfunction

endpackage

// File: rtl/rotor_step_controller_if.sv
// Bus between the keyboard/datapath side (master) and the rotor step controller (slave).
interface rotor_step_controller_if;
    import enigma_pkg::*;

    // key_ready is a level held while a make-code is present; the controller
    // consumes one press per rising edge of its registered copy. enc_valid is
    // a one-cycle strobe qualifying enc_letter; there is no back-pressure.
    logic                key_ready;
    logic [LETTER_W-1:0] key_code;
    logic                set;
    logic                set_sel;
    logic [LETTER_W-1:0] set_state;
    logic [LETTER_W-1:0] enc_result;
    logic [LETTER_W-1:0] rotor1_pos;
    logic [LETTER_W-1:0] rotor2_pos;
    logic [LETTER_W-1:0] enc_in;
    logic                enc_valid;
    logic [LETTER_W-1:0] enc_letter;
    logic                busy;

    modport master (
        output key_ready, key_code, set, set_sel, set_state, enc_result,
        input  rotor1_pos, rotor2_pos, enc_in, enc_valid, enc_letter, busy
    );

    modport slave (
        input  key_ready, key_code, set, set_sel, set_state, enc_result,
        output rotor1_pos, rotor2_pos, enc_in, enc_valid, enc_letter, busy
    );

endinterface

// File: rtl/rotor_pos_counter.sv
// Mod-26 rotor position register with synchronous load (priority) and an
// increment enable; at_notch flags the position that carries into the next rotor.
module rotor_pos_counter
    import enigma_pkg::*;
#(
    parameter logic [LETTER_W-1:0] NOTCH = LETTER_W'(NOTCH1_DEFAULT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_val,
    input  logic                inc,
    output logic [LETTER_W-1:0] pos,
    output logic                at_notch
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pos <= '0;
        end else if (load) begin
            pos <= load_val;
        end else if (inc) begin
            pos <= (pos == LAST_LETTER) ? '0 : pos + LETTER_W'(1);
        end
    end

    assign at_notch = (pos == NOTCH);

endmodule

// File: rtl/rotor_step_controller.sv
// Sequences one key press through rotor step, datapath settle and capture.
// Define PEND_BUF_EN to queue one press that arrives while busy.
module rotor_step_controller
    import enigma_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NOTCH1        = NOTCH1_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    rotor_step_controller_if.slave bus,
    output dbg_t                   dbg
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] STEP    = ST_STEP;
    localparam logic [1:0] SETTLE  = ST_SETTLE;
    localparam logic [1:0] CAPTURE = ST_CAPTURE;

    logic [1:0]          state;
    logic                key_q;
    logic                key_q_d;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [LETTER_W-1:0] enc_in;
    logic [LETTER_W-1:0] enc_letter;
    logic                enc_valid;
    logic [LETTER_W-1:0] r1_pos;
    logic [LETTER_W-1:0] r2_pos;
    logic                r1_notch;
    logic                r2_notch;
    logic                pend_full;
    logic [LETTER_W-1:0] pend_code;

    logic                in_idle;
    logic                press_ok;
    logic                set_take;
    logic                accept;
    logic [LETTER_W-1:0] set_val;

    assign in_idle  = (state == IDLE);
    assign press_ok = key_q && !key_q_d && (bus.key_code <= LAST_LETTER);
    assign set_take = in_idle && bus.set;
    // A set in the same cycle wins; the press edge is simply consumed.
    assign accept   = in_idle && press_ok && !bus.set;
    assign set_val  = letter_mod26(bus.set_state);

    rotor_pos_counter #(
        .NOTCH (LETTER_W'(NOTCH1))
    ) u_rotor1 (
        .clock    (clock),
        .reset    (reset),
        .load     (set_take && !bus.set_sel),
        .load_val (set_val),
        .inc      (state == STEP),
        .pos      (r1_pos),
        .at_notch (r1_notch)
    );

    rotor_pos_counter u_rotor2 (
        .clock    (clock),
        .reset    (reset),
        .load     (set_take && bus.set_sel),
        .load_val (set_val),
        .inc      ((state == STEP) && r1_notch),
        .pos      (r2_pos),
        .at_notch (r2_notch)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            key_q      <= 1'b0;
            key_q_d    <= 1'b0;
            settle_cnt <= '0;
            enc_in     <= '0;
            enc_letter <= '0;
            enc_valid  <= 1'b0;
        end else begin
            key_q     <= bus.key_ready;
            key_q_d   <= key_q;
            enc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        enc_in <= bus.key_code;
                        state  <= STEP;
                    end
                end
                STEP: begin
                    settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - SETTLE_W'(1);
                    if (settle_cnt <= SETTLE_W'(1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    enc_letter <= bus.enc_result;
                    enc_valid  <= 1'b1;
                    if (pend_full) begin
                        enc_in <= pend_code;
                        state  <= STEP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PEND_BUF_EN
    // Draining in CAPTURE takes priority, so a press landing there is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_full <= 1'b0;
            pend_code <= '0;
        end else if ((state == CAPTURE) && pend_full) begin
            pend_full <= 1'b0;
        end else if (!in_idle && press_ok && !pend_full) begin
            pend_full <= 1'b1;
            pend_code <= bus.key_code;
        end
    end
`else
    assign pend_full = 1'b0;
    assign pend_code = '0;
`endif

    assign bus.rotor1_pos = r1_pos;
    assign bus.rotor2_pos = r2_pos;
    assign bus.enc_in     = enc_in;
    assign bus.enc_valid  = enc_valid;
    assign bus.enc_letter = enc_letter;
    assign bus.busy       = !in_idle;

    always_comb begin
        dbg            = '0;
        dbg.state      = state;
        dbg.settle_cnt = settle_cnt;
        dbg.r1_notch   = r1_notch;
        dbg.r2_notch   = r2_notch;
        dbg.pend_full  = pend_full;
    end

endmodule

// File: tb/tb_rotor_step_controller.sv
// Bench for rotor_step_controller: reset, table vectors, corner sequences and
// randomized presses/sets against a letter-level rotor model.
module tb_rotor_step_controller;
    import enigma_pkg::*;

    localparam int SETTLE = 2;
    localparam int NOTCH  = 16;
    localparam int LAT    = SETTLE + 3;
    localparam int NV     = 14;

    typedef struct {
        bit is_press;
        bit sel;
        int val;
        int exp_r1;
        int exp_r2;
        int exp_valid;
        int exp_letter;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    dbg_t dbg;

    rotor_step_controller_if bus();

    rotor_step_controller #(
        .SETTLE_CYCLES (SETTLE),
        .NOTCH1        (NOTCH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .dbg   (dbg)
    );

    always #5 clock = ~clock;

    // Stand-in for the rotor/reflector datapath.
    function automatic int dp(input int code, input int r1, input int r2);
        return (code + r1 + 2 * r2) % 26;
    endfunction

    assign bus.enc_result = LETTER_W'(dp(int'(bus.enc_in), int'(bus.rotor1_pos), int'(bus.rotor2_pos)));

    int n_vec = 0;
    int n_err = 0;
    int cyc, vcnt, first_v, last_letter;
    bit busy_seen;
    int r1_hist[128];
    int m_r1, m_r2;
    vec_t tbl[NV];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; vcnt = 0; first_v = -1; last_letter = -1; busy_seen = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.enc_valid === 1'b1) begin
            if (vcnt == 0) first_v = cyc;
            vcnt++;
            last_letter = int'(bus.enc_letter);
        end
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        if (cyc < 128) r1_hist[cyc] = int'(bus.rotor1_pos);
        cyc++;
    endtask

    task automatic press_op(input int code, input int hold, input int window);
        clear_mon();
        @(negedge clock);
        bus.key_code  = LETTER_W'(code);
        bus.key_ready = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        @(negedge clock);
        bus.key_ready = 1'b0;
        for (int i = hold; i < window; i++) tick();
    endtask

    task automatic set_op(input bit sel, input int val);
        clear_mon();
        @(negedge clock);
        bus.set       = 1'b1;
        bus.set_sel   = sel;
        bus.set_state = LETTER_W'(val);
        tick();
        @(negedge clock);
        bus.set = 1'b0;
        for (int i = 1; i < 6; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; bus.key_ready = 1'b0; bus.set = 1'b0;
        tick(); tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int code, hold, val, exp_v, exp_l;
        bit sel, notch;

        reset = 1'b1;
        bus.key_ready = 1'b1; bus.key_code = 5'd3;
        bus.set = 1'b1; bus.set_sel = 1'b0; bus.set_state = 5'd9;

        // Reset must dominate a held key and a set request.
        clear_mon();
        tick(); tick(); tick();
        check("rst rotor1", int'(bus.rotor1_pos), 0);
        check("rst rotor2", int'(bus.rotor2_pos), 0);
        check("rst enc_in", int'(bus.enc_in), 0);
        check("rst enc_letter", int'(bus.enc_letter), 0);
        check("rst enc_valid", int'(bus.enc_valid), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst state", int'(dbg.state), int'(ST_IDLE));
        check("rst pend", int'(dbg.pend_full), 0);
        @(negedge clock);
        reset = 1'b0; bus.key_ready = 1'b0; bus.set = 1'b0;
        tick(); tick();

        // is_press, sel, val, r1, r2, valid, letter
        tbl[0]  = '{0, 0, 16, 16,  0, 0,  0};
        tbl[1]  = '{0, 1,  3, 16,  3, 0,  0};
        tbl[2]  = '{1, 0,  0, 17,  4, 1, 25};
        tbl[3]  = '{0, 0, 25, 25,  4, 0,  0};
        tbl[4]  = '{1, 0,  7,  0,  4, 1, 15};
        tbl[5]  = '{0, 1, 31,  0,  5, 0,  0};
        tbl[6]  = '{0, 0, 15, 15,  5, 0,  0};
        tbl[7]  = '{1, 0, 31, 15,  5, 0,  0};
        tbl[8]  = '{1, 0,  3, 16,  5, 1,  3};
        tbl[9]  = '{1, 0,  3, 17,  6, 1,  6};
        tbl[10] = '{0, 1, 25, 17, 25, 0,  0};
        tbl[11] = '{0, 0, 16, 16, 25, 0,  0};
        tbl[12] = '{1, 0, 20, 17,  0, 1, 11};
        tbl[13] = '{0, 0, 26,  0,  0, 0,  0};

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].is_press) press_op(tbl[i].val, 2, 10);
            else set_op(tbl[i].sel, tbl[i].val);
            check($sformatf("tbl%0d rotor1", i), int'(bus.rotor1_pos), tbl[i].exp_r1);
            check($sformatf("tbl%0d rotor2", i), int'(bus.rotor2_pos), tbl[i].exp_r2);
            check($sformatf("tbl%0d valid_cnt", i), vcnt, tbl[i].exp_valid);
            check($sformatf("tbl%0d busy_seen", i), int'(busy_seen), tbl[i].exp_valid);
            if (tbl[i].exp_valid != 0) begin
                check($sformatf("tbl%0d latency", i), first_v, LAT);
                check($sformatf("tbl%0d letter", i), last_letter, tbl[i].exp_letter);
            end
        end

        // Step happens on the edge leaving STEP; strobe lands SETTLE+3 edges in.
        press_op(0, 2, 10);
        check("seq rotor1 after e1", r1_hist[1], 0);
        check("seq rotor1 after e2", r1_hist[2], 1);
        check("seq latency", first_v, LAT);
        check("seq valid_cnt", vcnt, 1);
        check("seq letter", last_letter, dp(0, 1, 0));

        press_op(5, 100, 106);
        check("hold100 valid_cnt", vcnt, 1);
        check("hold100 rotor1", int'(bus.rotor1_pos), 2);

        // Set and press edge coincide: set loads 30 mod 26, press is dropped.
        clear_mon();
        @(negedge clock);
        bus.key_code = 5'd9; bus.key_ready = 1'b1;
        bus.set = 1'b1; bus.set_sel = 1'b1; bus.set_state = 5'd30;
        tick(); tick();
        @(negedge clock);
        bus.set = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        @(negedge clock);
        bus.key_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("setpress rotor2", int'(bus.rotor2_pos), 4);
        check("setpress rotor1", int'(bus.rotor1_pos), 2);
        check("setpress valid_cnt", vcnt, 0);
        check("setpress busy_seen", int'(busy_seen), 0);

        // Reset landing in SETTLE aborts without a strobe.
        clear_mon();
        @(negedge clock);
        bus.key_code = 5'd4; bus.key_ready = 1'b1;
        tick(); tick(); tick();
        check("abort in settle", int'(dbg.state), int'(ST_SETTLE));
        @(negedge clock);
        reset = 1'b1; bus.key_ready = 1'b0;
        tick();
        check("abort state", int'(dbg.state), int'(ST_IDLE));
        check("abort rotor1", int'(bus.rotor1_pos), 0);
        check("abort rotor2", int'(bus.rotor2_pos), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort valid_cnt", vcnt, 0);

        // Presses A, B (during SETTLE) and C (while B is pending).
        clear_mon();
        @(negedge clock); bus.key_code = 5'd2; bus.key_ready = 1'b1;
        tick();
        @(negedge clock); bus.key_ready = 1'b0;
        tick();
        @(negedge clock); bus.key_code = 5'd6; bus.key_ready = 1'b1;
        tick();
        @(negedge clock); bus.key_ready = 1'b0;
        tick();
        @(negedge clock); bus.key_code = 5'd8; bus.key_ready = 1'b1;
        tick();
        @(negedge clock); bus.key_ready = 1'b0;
        for (int i = 5; i < 20; i++) tick();
        check("busy_press latency", first_v, LAT);
`ifdef PEND_BUF_EN
        check("pend valid_cnt", vcnt, 2);
        check("pend rotor1", int'(bus.rotor1_pos), 2);
        check("pend letter", last_letter, dp(6, 2, 0));
`else
        check("busy_press valid_cnt", vcnt, 1);
        check("busy_press rotor1", int'(bus.rotor1_pos), 1);
        check("busy_press letter", last_letter, dp(2, 1, 0));
`endif

        do_reset();
        m_r1 = 0; m_r2 = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = 1'($urandom_range(0, 1));
                val = int'($urandom_range(0, 31));
                set_op(sel, val);
                if (sel) m_r2 = val % 26;
                else m_r1 = val % 26;
                exp_v = 0; exp_l = 0;
            end else begin
                code = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 25));
                hold = int'($urandom_range(1, 6));
                press_op(code, hold, 10);
                exp_v = 0; exp_l = 0;
                if (code < 26) begin
                    notch = (m_r1 == NOTCH);
                    m_r1 = (m_r1 + 1) % 26;
                    if (notch) m_r2 = (m_r2 + 1) % 26;
                    exp_v = 1;
                    exp_l = dp(code, m_r1, m_r2);
                end
            end
            check($sformatf("rnd%0d rotor1", i), int'(bus.rotor1_pos), m_r1);
            check($sformatf("rnd%0d rotor2", i), int'(bus.rotor2_pos), m_r2);
            check($sformatf("rnd%0d valid_cnt", i), vcnt, exp_v);
            if (exp_v != 0) begin
                check($sformatf("rnd%0d latency", i), first_v, LAT);
                check($sformatf("rnd%0d letter", i), last_letter, exp_l);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
